mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data memory arbiter: read-return owner
// encoding and default parameter values.
package mem_arb_pkg;

    localparam int DEF_STARVE_MAX = 3;
    localparam int DEF_AW         = 16;

    // Who owns the RAM read data returning in the current cycle.
    typedef enum logic [1:0] {
        NONE     = 2'd0,
        FETCH_RD = 2'd1,
        DATA_RD  = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter (instruction fetch, data load/store) onto one single-port
// synchronous RAM. Grants are combinational; read data returns one cycle later
// and is steered back to whichever requester issued the read.
//
// Handshake: a requester raises *_req with its address/data stable and keeps
// them stable until it sees *_gnt high in the same cycle; the access is taken
// on that rising edge. A read answers with a one-cycle *_rvalid pulse exactly
// one cycle after its grant; writes complete in the grant cycle and never
// produce *_rvalid. Dropping a request before its grant cancels it.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX,
    parameter int AW         = DEF_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [AW-1:0] f_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [AW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [AW-1:0] d_rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [AW-1:0] ram_wdata,
    input  logic [AW-1:0] ram_rdata,
    output logic [15:0]   conflict_cnt,
    output owner_e        owner_dbg
);

    // Wide enough to hold STARVE_MAX itself (at least one bit).
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    owner_e        owner_q,    owner_d;
    logic [SW-1:0] starve_q,   starve_d;
    logic [15:0]   conflict_q, conflict_d;
    logic          fetch_turn;

    // Grant decision: data has priority unless fetch has waited STARVE_MAX grants.
    always_comb begin
        fetch_turn = f_req && (starve_q == STARVE_LIM);
        f_gnt      = 1'b0;
        d_gnt      = 1'b0;
        if (!reset) begin
            if (fetch_turn) begin
                f_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end else if (f_req) begin
                f_gnt = 1'b1;
            end
        end
    end

    // RAM strobe and address/data mux from whichever requester holds the grant.
    always_comb begin
        ram_en    = f_gnt | d_gnt;
        ram_we    = d_gnt & d_we;
        ram_addr  = '0;
        ram_wdata = '0;
        if (d_gnt) begin
            ram_addr  = d_addr;
            ram_wdata = d_wdata;
        end else if (f_gnt) begin
            ram_addr  = f_addr;
        end
    end

    // Next-state for return owner, starvation counter and conflict counter.
    always_comb begin
        owner_d    = NONE;
        starve_d   = starve_q;
        conflict_d = conflict_q;

        if (f_gnt) begin
            owner_d = FETCH_RD;
        end else if (d_gnt && !d_we) begin
            owner_d = DATA_RD;
        end

        if (f_gnt || !f_req) begin
            starve_d = '0;
        end else if (d_gnt && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + SW'(1);
        end

        if (f_req && d_req && (conflict_q != 16'hFFFF)) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    // State registers; reset drops any read return still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q    <= NONE;
            starve_q   <= '0;
            conflict_q <= '0;
        end else begin
            owner_q    <= owner_d;
            starve_q   <= starve_d;
            conflict_q <= conflict_d;
        end
    end

    // Read-return steering; data lines stay at zero when not valid.
    always_comb begin
        f_rvalid = (owner_q == FETCH_RD);
        d_rvalid = (owner_q == DATA_RD);
        f_rdata  = f_rvalid ? ram_rdata : '0;
        d_rdata  = d_rvalid ? ram_rdata : '0;
    end

    assign conflict_cnt = conflict_q;
    assign owner_dbg    = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: external RAM model, a cycle-level reference model of
// the arbitration rules, directed scenarios and a randomized traffic phase.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 16;
    localparam int SM = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          f_req = 1'b0;
    logic [AW-1:0] f_addr = '0;
    logic          f_gnt, f_rvalid;
    logic [AW-1:0] f_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [AW-1:0] d_wdata = '0;
    logic          d_gnt, d_rvalid;
    logic [AW-1:0] d_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr, ram_wdata;
    logic [AW-1:0] ram_rdata = '0;
    logic [15:0]   conflict_cnt;
    owner_e        owner_dbg;

    mem_arbiter #(.STARVE_MAX(SM), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .conflict_cnt(conflict_cnt), .owner_dbg(owner_dbg)
    );

    // Initial RAM contents, shared by the RAM model and the reference copy.
    function automatic logic [15:0] init_word(input int i);
        if (i == 16'h0010) return 16'hBEEF;
        return 16'(i * 37 + 5) ^ 16'hA5A5;
    endfunction

    // ---------------- external RAM (256 words, low address bits) ----------------
    logic [15:0] ram_mem [256];
    logic        mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (ram_en) begin
            if (ram_we) ram_mem[ram_addr[7:0]] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr[7:0]];
        end
    end

    // ---------------- scoreboard / reference model ----------------
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] ref_mem [256];
    logic [AW+1:0] exp_q[$];   // {tag, data}: tag 01 = fetch, 10 = data
    int          m_starve = 0; // data grants in a row while fetch waits
    int          m_conf = 0;
    logic        granted_f, granted_d;
    logic        obs_f_gnt;
    logic [15:0] obs_f_rdata, obs_d_rdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle with the current inputs: check at negedge, advance model at posedge.
    task automatic step();
        logic ef, ed, hv;
        logic [AW+1:0] head;
        @(negedge clk);
        ef = f_req && (!d_req || m_starve == SM);
        ed = d_req && !ef;
        check_eq("f_gnt", f_gnt, ef);
        check_eq("d_gnt", d_gnt, ed);
        check_eq("ram_en", ram_en, ef | ed);
        check_eq("ram_we", ram_we, ed & d_we);
        if (ef) begin
            check_eq("ram_addr_f", ram_addr, f_addr);
            check_eq("ram_wdata_f", ram_wdata, 0);
        end
        if (ed) begin
            check_eq("ram_addr_d", ram_addr, d_addr);
            check_eq("ram_wdata_d", ram_wdata, d_wdata);
        end
        hv   = (exp_q.size() > 0);
        head = hv ? exp_q.pop_front() : '0;
        check_eq("f_rvalid", f_rvalid, hv && head[AW+1:AW] == 2'b01);
        check_eq("d_rvalid", d_rvalid, hv && head[AW+1:AW] == 2'b10);
        check_eq("f_rdata", f_rdata, (hv && head[AW+1:AW] == 2'b01) ? head[AW-1:0] : 16'h0);
        check_eq("d_rdata", d_rdata, (hv && head[AW+1:AW] == 2'b10) ? head[AW-1:0] : 16'h0);
        check_eq("conflict_cnt", conflict_cnt, m_conf);
        obs_f_gnt   = f_gnt;
        obs_f_rdata = f_rdata;
        obs_d_rdata = d_rdata;
        granted_f   = ef;
        granted_d   = ed;
        @(posedge clk);
        if (ef) exp_q.push_back({2'b01, ref_mem[f_addr[7:0]]});
        if (ed && !d_we) exp_q.push_back({2'b10, ref_mem[d_addr[7:0]]});
        if (ed && d_we) ref_mem[d_addr[7:0]] = d_wdata;
        if (f_req && d_req && m_conf < 65535) m_conf++;
        if (!f_req || ef) m_starve = 0;
        else if (ed && m_starve < SM) m_starve++;
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_fg"}, f_gnt, 0);
        check_eq({tag, "_dg"}, d_gnt, 0);
        check_eq({tag, "_frv"}, f_rvalid, 0);
        check_eq({tag, "_drv"}, d_rvalid, 0);
        check_eq({tag, "_frd"}, f_rdata, 0);
        check_eq({tag, "_drd"}, d_rdata, 0);
        check_eq({tag, "_en"}, ram_en, 0);
        check_eq({tag, "_we"}, ram_we, 0);
        check_eq({tag, "_addr"}, ram_addr, 0);
        check_eq({tag, "_wdata"}, ram_wdata, 0);
        check_eq({tag, "_conf"}, conflict_cnt, 0);
        check_eq({tag, "_owner"}, owner_dbg, NONE);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_starve = 0;
        m_conf   = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        model_reset();

        // Reset state with both requesters active.
        f_req = 1'b1; f_addr = 16'h0042;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0077; d_wdata = 16'h9999;
        #12;
        check_all_zero("rst");
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst_clk");
        reset = 1'b0;

        // Fetch read of 0x0010, first cycle after reset release.
        f_req = 1'b1; f_addr = 16'h0010; d_req = 1'b0;
        step();
        check_eq("fetch_first_gnt", obs_f_gnt, 1);
        f_req = 1'b0;
        step();
        check_eq("fetch_beef", obs_f_rdata, 16'hBEEF);

        // Data write then read-back of 0x0020.
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
        step();
        d_we = 1'b0; d_wdata = 16'h0;
        step();
        d_req = 1'b0;
        step();
        check_eq("data_rd_1234", obs_d_rdata, 16'h1234);

        // Both requesting continuously: D,D,D,F pattern.
        for (int i = 0; i < 12; i++) begin
            f_req = 1'b1; f_addr = 16'($urandom);
            d_req = 1'b1; d_we = 1'b0; d_addr = 16'($urandom);
            step();
            check_eq("starve_seq", obs_f_gnt, (i % 4) == 3);
        end
        f_req = 1'b0; d_req = 1'b0;
        step();

        // Alternating single-requester reads back to back.
        for (int i = 0; i < 16; i++) begin
            f_req = (i % 2 == 0); f_addr = 16'($urandom);
            d_req = (i % 2 == 1); d_we = 1'b0; d_addr = 16'($urandom);
            step();
        end
        f_req = 1'b0; d_req = 1'b0;
        step();

        // Randomized traffic with holds, drops, reads and writes.
        for (int i = 0; i < 600; i++) begin
            if (f_req && !granted_f) begin
                if ($urandom_range(0, 15) == 0) f_req = 1'b0;
            end else begin
                f_req  = ($urandom_range(0, 2) != 0);
                f_addr = 16'($urandom);
            end
            if (d_req && !granted_d) begin
                if ($urandom_range(0, 15) == 0) d_req = 1'b0;
            end else begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = ($urandom_range(0, 1) == 1);
                d_addr  = 16'($urandom);
                d_wdata = 16'($urandom);
            end
            step();
        end
        f_req = 1'b0; d_req = 1'b0;
        step();

        // Reset one cycle after a data read grant.
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0030;
        step();
        reset = 1'b1;
        f_req = 1'b1; f_addr = 16'h0011;
        d_we = 1'b1; d_wdata = 16'h5555;
        #1;
        model_reset();
        check_all_zero("rst_mid");
        @(posedge clk);
        #1;
        check_all_zero("rst_mid_clk");
        reset = 1'b0;
        f_req = 1'b0; d_we = 1'b0; d_addr = 16'h0031;
        step();
        check_eq("post_rst_gnt", granted_d, 1);
        d_req = 1'b0;
        step();
        check_eq("post_rst_rd", obs_d_rdata, ref_mem[8'h31]);

        // Conflict counter saturation.
        for (int i = 0; i < 70000; i++) begin
            f_req = 1'b1; f_addr = 16'($urandom);
            d_req = 1'b1; d_we = 1'b0; d_addr = 16'($urandom);
            step();
        end
        @(negedge clk);
        check_eq("conf_sat", conflict_cnt, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
